operand_sequencer: RTL and testbench

Front-end job sequencer for the `projetoFinal` compute core. It buffers operand sets (A, B, C, K) in a small FIFO and issues them one at a time over the core's `inicio`/`pronto` handshake. It captures each `resultado` and presents it on a valid/ready output port. It sits directly upstream of `projetoFinal` and replaces the hand-driven `inicio` used in standalone bring-up.

---
 rtl/seq_pkg.sv | 28 ++
 rtl/operand_fifo.sv | 73 +++++++
 rtl/operand_sequencer.sv | 171 +++++++++++++++++
 tb/tb_operand_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding, default widths and operand-set type for operand_sequencer
package seq_pkg;

  localparam int SEQ_W  = 16;
  localparam int SEQ_KW = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } seq_state_e;

  typedef struct packed {
    logic [SEQ_W-1:0]  a;
    logic [SEQ_W-1:0]  b;
    logic [SEQ_W-1:0]  c;
    logic [SEQ_KW-1:0] k;
  } operand_set_t;

  // Watchdog is never narrower than 8 bits so small TIMEOUT values still fit.
  function automatic int wd_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/operand_fifo.sv
// rtl/operand_fifo.sv - synchronous FIFO of operand sets with push/pop/full/empty/level
module operand_fifo
  import seq_pkg::*;
#(
  parameter type T     = operand_set_t,
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  T                       wdata_i,
  output logic                   full_o,
  input  logic                   pop_i,
  output T                       rdata_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

  // A full FIFO refuses the push even when a pop frees a slot in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = count_q;

endmodule

// File: rtl/operand_sequencer.sv
// rtl/operand_sequencer.sv - queues operand sets and issues them to the core over inicio/pronto
// Define SEQ_TIMEOUT_EN to abort a job that stays in RUN for TIMEOUT cycles.
module operand_sequencer
  import seq_pkg::*;
#(
  parameter int W       = SEQ_W,
  parameter int KW      = SEQ_KW,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_a,
  input  logic [W-1:0]           in_b,
  input  logic [W-1:0]           in_c,
  input  logic [KW-1:0]          in_k,
  output logic [W-1:0]           core_a,
  output logic [W-1:0]           core_b,
  output logic [W-1:0]           core_c,
  output logic [KW-1:0]          core_k,
  output logic                   core_inicio,
  input  logic                   core_pronto,
  input  logic [W-1:0]           core_resultado,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_resultado,
  output logic                   out_timeout,
  output logic [$clog2(DEPTH):0] level
);

  typedef struct packed {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  c;
    logic [KW-1:0] k;
  } op_t;

  seq_state_e   state_q, state_d;
  op_t          fifo_wdata, fifo_rdata;
  op_t          ops_q, ops_d;
  logic [W-1:0] res_q, res_d;
  logic         fifo_full, fifo_empty;
  logic         pop;
  logic         capture;
  logic         abort;
  logic         timeout_hit;

  assign fifo_wdata = '{a: in_a, b: in_b, c: in_c, k: in_k};

  operand_fifo #(
    .T     (op_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .wdata_i (fifo_wdata),
    .full_o  (fifo_full),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign in_ready = !fifo_full;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        // A result arriving on the same cycle as the watchdog expiry wins.
        if (core_pronto) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ops_d = ops_q;
    res_d = res_q;
    if (pop) begin
      ops_d = fifo_rdata;
    end
    if (capture) begin
      res_d = core_resultado;
    end else if (abort) begin
      res_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ops_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ops_q   <= ops_d;
      res_q   <= res_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int WDW = wd_width(TIMEOUT);

  logic [WDW-1:0] wd_q, wd_d;
  logic           tmo_q, tmo_d;

  // The counter sits at zero outside RUN, so it is already cleared on entry.
  always_comb begin
    wd_d  = (state_q == S_RUN) ? wd_q + WDW'(1) : '0;
    tmo_d = tmo_q;
    if (capture) begin
      tmo_d = 1'b0;
    end else if (abort) begin
      tmo_d = 1'b1;
    end
  end

  assign timeout_hit = (state_q == S_RUN) && (wd_q == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      tmo_q <= tmo_d;
    end
  end

  assign out_timeout = tmo_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign out_timeout    = 1'b0;
`endif

  assign core_a        = ops_q.a;
  assign core_b        = ops_q.b;
  assign core_c        = ops_q.c;
  assign core_k        = ops_q.k;
  assign core_inicio   = (state_q == S_RUN);
  assign out_valid     = (state_q == S_DONE);
  assign out_resultado = res_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// tb/tb_operand_sequencer.sv - self-checking bench for operand_sequencer with a behavioural core model
module tb_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0, in_b = '0, in_c = '0;
  logic [7:0]  in_k = '0;
  logic [15:0] core_a, core_b, core_c;
  logic [7:0]  core_k;
  logic        core_inicio;
  logic        core_pronto;
  logic [15:0] core_resultado;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_resultado;
  logic        out_timeout;
  logic [2:0]  level;

  logic        force_pronto = 1'b0;
  logic        no_pronto = 1'b0;
  logic        mpronto = 1'b0;
  int          mcnt = 0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          push_cyc = 0;
  int          hs_edge = -1;
  logic        sb_en = 1'b0;
  logic        gap_en = 1'b0;
  logic        prev_ini = 1'b0;
  logic [15:0] e;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  operand_sequencer #(
    .W(16), .KW(8), .DEPTH(4), .TIMEOUT(20)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_k(in_k),
    .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_k(core_k),
    .core_inicio(core_inicio), .core_pronto(core_pronto), .core_resultado(core_resultado),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_resultado(out_resultado), .out_timeout(out_timeout),
    .level(level)
  );

  // Core model: result A+B+C+K, pronto K+2 cycles after inicio rises.
  assign core_pronto    = mpronto | force_pronto;
  assign core_resultado = force_pronto ? 16'hDEAD : (core_a + core_b + core_c + 16'(core_k));

  always @(negedge clk) begin
    if (rst || !core_inicio) begin
      mcnt    = 0;
      mpronto = 1'b0;
    end else begin
      mcnt++;
      mpronto = !no_pronto && (mcnt >= int'(core_k) + 2);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_extra_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", 32'(out_resultado), 32'(e));
        check("sb_timeout", 32'(out_timeout), 32'd0);
      end
      hs_edge = cyc + 1;
    end
    if (gap_en && core_inicio && !prev_ini && hs_edge >= 0) begin
      check("job_gap", 32'(cyc - hs_edge), 32'd2);
    end
    prev_ini = core_inicio;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                      input logic [7:0] k, input bit track);
    int n = 0;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_c = c; in_k = k;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("push_accept", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    push_cyc = cyc;
    if (track) exp_q.push_back(a + b + c + 16'(k));
  endtask

  task automatic wait_valid(output int c);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("wait_out_valid", 32'd0, 32'd1);
    c = cyc;
  endtask

  task automatic wait_inicio(output int c);
    int n = 0;
    @(negedge clk);
    while (!core_inicio && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!core_inicio) check("wait_core_inicio", 32'd0, 32'd1);
    c = cyc;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_results", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic accept_one();
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("release_valid", 32'(out_valid), 32'd0);
    tick();
  endtask

  typedef struct {
    logic [15:0] a, b, c;
    logic [7:0]  k;
    logic [15:0] res;
    int          lat;
  } vec_t;

  vec_t vt[5];

  initial begin
    int r, q, cnt, vlow, chg;

    vt[0] = '{a: 16'd5,     b: 16'd3,     c: 16'd9,   k: 8'd4,   res: 16'd21,    lat: 8};
    vt[1] = '{a: 16'd0,     b: 16'd0,     c: 16'd0,   k: 8'd0,   res: 16'd0,     lat: 4};
    vt[2] = '{a: 16'hFFFF,  b: 16'd1,     c: 16'd0,   k: 8'd0,   res: 16'd0,     lat: 4};
    vt[3] = '{a: 16'd100,   b: 16'd200,   c: 16'd300, k: 8'd10,  res: 16'd610,   lat: 14};
    vt[4] = '{a: 16'h8000,  b: 16'h8000,  c: 16'd7,   k: 8'd255, res: 16'h0106,  lat: 259};

    // Reset values
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_inicio", 32'(core_inicio), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_timeout", 32'(out_timeout), 32'd0);
    check("rst_core_a", 32'(core_a), 32'd0);
    check("rst_out_resultado", 32'(out_resultado), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single jobs from the table, including latency from push
    for (int i = 0; i < 5; i++) begin
      push(vt[i].a, vt[i].b, vt[i].c, vt[i].k, 1'b0);
      wait_inicio(r);
      check("tbl_inicio_lat", 32'(r - push_cyc), 32'd2);
      wait_valid(q);
      check("tbl_valid_lat", 32'(q - push_cyc), 32'(vt[i].lat));
      check("tbl_result", 32'(out_resultado), 32'(vt[i].res));
      check("tbl_timeout", 32'(out_timeout), 32'd0);
      accept_one();
    end

    // pronto outside RUN: IDLE then DONE
    force_pronto = 1'b1;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid || core_inicio) cnt++;
    end
    tick();
    force_pronto = 1'b0;
    check("idle_pronto_ignored", 32'(cnt), 32'd0);
    push(16'd1, 16'd1, 16'd1, 8'd1, 1'b0);
    wait_valid(q);
    tick();
    force_pronto = 1'b1;
    tick();
    tick();
    force_pronto = 1'b0;
    @(negedge clk);
    check("done_pronto_result", 32'(out_resultado), 32'd4);
    check("done_pronto_valid", 32'(out_valid), 32'd1);
    accept_one();
    vlow = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) vlow++;
    end
    check("no_extra_valid", 32'(vlow), 32'd0);
    tick();

    // Ordering with continuous out_ready and gap between jobs
    sb_en = 1'b1;
    out_ready = 1'b1;
    hs_edge = -1;
    gap_en = 1'b1;
    push(16'd1, 16'd1, 16'd1, 8'd1, 1'b1);
    push(16'd2, 16'd2, 16'd2, 8'd2, 1'b1);
    push(16'd3, 16'd3, 16'd3, 8'd3, 1'b1);
    drain();
    gap_en = 1'b0;
    tick();

    // Back-pressure: five jobs with the consumer stalled
    out_ready = 1'b0;
    for (int j = 1; j <= 5; j++) push(16'(j), 16'd0, 16'd0, 8'd2, 1'b1);
    @(negedge clk);
    check("bp_level_full", 32'(level), 32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    wait_valid(q);
    cnt = 0; vlow = 0; chg = 0;
    repeat (15) begin
      @(negedge clk);
      if (core_inicio) cnt++;
      if (!out_valid) vlow++;
      if (out_resultado != 16'd3) chg++;
    end
    check("bp_no_inicio", 32'(cnt), 32'd0);
    check("bp_valid_held", 32'(vlow), 32'd0);
    check("bp_result_stable", 32'(chg), 32'd0);
    check("bp_level_held", 32'(level), 32'd4);
    tick();
    out_ready = 1'b1;
    drain();
    repeat (3) @(negedge clk);
    check("bp_level_empty", 32'(level), 32'd0);
    tick();

    // Reset in the middle of RUN with two jobs queued
    push(16'd0, 16'd0, 16'd0, 8'd50, 1'b1);
    push(16'd1, 16'd1, 16'd1, 8'd1, 1'b1);
    push(16'd2, 16'd2, 16'd2, 8'd2, 1'b1);
    wait_inicio(r);
    check("mid_run_level", 32'(level), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_inicio", 32'(core_inicio), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_core_k", 32'(core_k), 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    push(16'd5, 16'd3, 16'd9, 8'd4, 1'b1);
    drain();
    tick();

`ifdef SEQ_TIMEOUT_EN
    // Watchdog abort then a normal job
    sb_en = 1'b0;
    out_ready = 1'b0;
    no_pronto = 1'b1;
    push(16'd1, 16'd2, 16'd3, 8'd4, 1'b0);
    wait_inicio(r);
    wait_valid(q);
    check("to_run_cycles", 32'(q - r), 32'd20);
    check("to_flag", 32'(out_timeout), 32'd1);
    check("to_result", 32'(out_resultado), 32'd0);
    accept_one();
    no_pronto = 1'b0;
    push(16'd1, 16'd2, 16'd3, 8'd4, 1'b0);
    wait_valid(q);
    check("to_next_result", 32'(out_resultado), 32'd10);
    check("to_next_flag", 32'(out_timeout), 32'd0);
    accept_one();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
